// File: rtl/password_pkg.sv
// Shared definitions for the password enroller, checker and password store.
package password_pkg;

  localparam int WORD_W    = 16;
  localparam int MAX_WORDS = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER1 = 3'd1,
    ST_ENTER2 = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } enroll_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// 4-bit value to active-low 7-segment pattern (bit 0 = segment a, bit 6 = segment g).
module hex_to_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Decode a hex digit to its segment pattern.
  always_comb begin
    seg_n = 7'h7F;
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/password_enroller.sv
// Captures a new password twice from the switches and, when both passes agree,
// writes it word by word into the shared password store.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE   0  | waiting for unlocked && enroll_en
// ENTER1 1  | first pass, one word captured per edge into the buffer
// ENTER2 2  | second pass, each word compared against the buffer
// COMMIT 3  | valid/ready write of buffer[idx] to the store
// DONE   4  | password written, wait for enroll_en to drop
// FAIL   5  | passes differed, nothing written, wait for enroll_en to drop
//
// A reset during COMMIT can leave the store holding a mix of old and new words.
module password_enroller
  import password_pkg::*;
#(
  parameter int N_WORDS = 4
) (
  input  logic              key,
  input  logic              reset,
  input  logic              unlocked,
  input  logic [17:0]       s,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic [17:0]       LED,
  output logic [6:0]        seg0,
  output logic [6:0]        seg1,
  output logic [6:0]        seg2,
  output logic [6:0]        seg3
);

  enroll_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mismatch_q, mismatch_d;
  logic [WORD_W-1:0] word_buf_q [MAX_WORDS];
  logic [WORD_W-1:0] word_buf_d [MAX_WORDS];
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic              enroll_en;
  logic [WORD_W-1:0] word_in;
  logic              last_word;
  logic [ADDR_W-1:0] idx_inc;
  logic              mismatch_now;
  logic              busy;
  logic [17:0]       led_c;
  logic              unused_s16;

  assign enroll_en    = s[17];
  assign word_in      = s[15:0];
  assign unused_s16   = s[16];
  assign last_word    = (idx_q == ADDR_W'(N_WORDS - 1));
  assign idx_inc      = idx_q + ADDR_W'(1);
  assign mismatch_now = mismatch_q | (word_in != word_buf_q[idx_q]);

  // State register.
  always_ff @(posedge key) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: index, compare flag, buffer and registered write port.
  always_ff @(posedge key) begin
    if (reset) begin
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < MAX_WORDS; i++) word_buf_q[i] <= '0;
    end else begin
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      for (int i = 0; i < MAX_WORDS; i++) word_buf_q[i] <= word_buf_d[i];
    end
  end

  // Next-state logic; an abort in either entry pass beats the capture/compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (unlocked && enroll_en) state_d = ST_ENTER1;
      ST_ENTER1: begin
        if (!enroll_en)     state_d = ST_IDLE;
        else if (last_word) state_d = ST_ENTER2;
      end
      ST_ENTER2: begin
        if (!enroll_en)     state_d = ST_IDLE;
        else if (last_word) state_d = mismatch_now ? ST_FAIL : ST_COMMIT;
      end
      ST_COMMIT: if (wr_ready && last_word) state_d = ST_DONE;
      ST_DONE,
      ST_FAIL:   if (!enroll_en) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; the write port is loaded one edge ahead so it is registered.
  always_comb begin
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    for (int i = 0; i < MAX_WORDS; i++) word_buf_d[i] = word_buf_q[i];
    case (state_q)
      ST_IDLE: idx_d = '0;
      ST_ENTER1: begin
        if (!enroll_en) begin
          idx_d = '0;
        end else begin
          word_buf_d[idx_q] = word_in;
          if (last_word) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      ST_ENTER2: begin
        if (!enroll_en) begin
          idx_d = '0;
        end else begin
          mismatch_d = mismatch_now;
          if (last_word) begin
            idx_d = '0;
            if (!mismatch_now) begin
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = word_buf_q[0];
            end
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      ST_COMMIT: begin
        wr_en_d = 1'b1;
        if (wr_ready) begin
          if (last_word) begin
            wr_en_d = 1'b0;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = idx_inc;
            wr_data_d = word_buf_q[idx_inc];
          end
        end
      end
      default: ;
    endcase
  end

  // Status LEDs derived from the current state and index.
  always_comb begin
    busy  = (state_q == ST_ENTER1) || (state_q == ST_ENTER2) || (state_q == ST_COMMIT);
    led_c = '0;
    if (busy) led_c[7:0] = 8'b1 << idx_q;
    led_c[15] = (state_q == ST_DONE);
    led_c[16] = (state_q == ST_FAIL);
    led_c[17] = busy;
  end

  assign LED     = led_c;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign seg2    = 7'h7F;
  assign seg3    = 7'h7F;

  hex_to_seg7 u_seg_idx (
    .hex   ({1'b0, idx_q}),
    .seg_n (seg0)
  );

  hex_to_seg7 u_seg_state (
    .hex   ({1'b0, state_q}),
    .seg_n (seg1)
  );

endmodule

// File: tb/tb_password_enroller.sv
// Scoreboard bench for password_enroller: expected store writes are queued when
// the second pass is driven and popped as the DUT hands them over.
module tb_password_enroller;

  logic        key = 1'b0;
  logic        reset;
  logic        unlocked;
  logic [17:0] s;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [17:0] LED;
  logic [6:0]  seg0, seg1, seg2, seg3;

  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] exp_q [$];

  localparam logic [63:0] PW_A   = {16'h092F, 16'h987A, 16'hEF93, 16'h4241};
  localparam logic [63:0] PW_BAD = {16'h092F, 16'hFFFF, 16'hEF93, 16'h4241};

  password_enroller #(.N_WORDS(4)) dut (
    .key      (key),
    .reset    (reset),
    .unlocked (unlocked),
    .s        (s),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .LED      (LED),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3)
  );

  always #5 key = ~key;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs right after a falling edge, then let one rising edge pass.
  task automatic drive(input logic en, input logic [15:0] d, input logic rdy);
    s        = {en, 1'b0, d};
    wr_ready = rdy;
    @(negedge key);
  endtask

  // Enter p1 then p2; ends in COMMIT (match) or FAIL (no match).
  task automatic enroll(input logic [63:0] p1, input logic [63:0] p2);
    drive(1'b1, 16'h0, 1'b1);
    chk("enter1_state", seg1, seg_of(4'd1));
    for (int i = 0; i < 4; i++) drive(1'b1, p1[16*i +: 16], 1'b1);
    chk("enter2_state", seg1, seg_of(4'd2));
    chk("enter2_led", LED, 32'h20001);
    if (p1 == p2)
      for (int i = 0; i < 4; i++) exp_q.push_back({3'(i), p1[16*i +: 16]});
    for (int i = 0; i < 4; i++) drive(1'b1, p2[16*i +: 16], 1'b1);
    if (p1 == p2) begin
      chk("commit_wr_en", wr_en, 1);
      chk("commit_addr0", wr_addr, 0);
      chk("commit_data0", wr_data, p1[15:0]);
    end else begin
      chk("fail_led", LED, 32'h10000);
      chk("fail_state", seg1, seg_of(4'd5));
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!LED[15] && k < 20) begin
      drive(1'b1, 16'h0, 1'b1);
      k++;
    end
    if (!LED[15]) chk("done_timeout", LED[15], 1);
  endtask

  task automatic leave_to_idle();
    drive(1'b0, 16'h0, 1'b1);
    chk("idle_state", seg1, seg_of(4'd0));
    chk("idle_led", LED, 0);
  endtask

  // Store-side monitor: accepted writes must match the scoreboard, in order.
  always @(negedge key) begin
    #3;
    if (wr_en) chk("wr_en_in_commit", seg1, seg_of(4'd3));
    if (wr_en && wr_ready && !reset) begin
      if (exp_q.size() == 0) begin
        chk("write_unexpected", wr_en, 0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e[18:16]);
        chk("wr_data", wr_data, e[15:0]);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; unlocked = 1'b0; s = '0; wr_ready = 1'b0;
    @(negedge key);
    drive(1'b0, 16'h0, 1'b0);
    reset = 1'b0;
    chk("rst_led", LED, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_seg0", seg0, 7'h40);
    chk("rst_seg1", seg1, 7'h40);
    chk("rst_seg2", seg2, 7'h7F);
    chk("rst_seg3", seg3, 7'h7F);

    // Not unlocked: enroll request is ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h1234, 1'b1);
      chk("locked_state", seg1, seg_of(4'd0));
      chk("locked_led", LED, 0);
    end

    // Successful enrollment with latency check.
    unlocked = 1'b1;
    enroll(PW_A, PW_A);
    wait_done(k);
    chk("latency", 8 + k, 12);
    chk("done_led", LED, 32'h8000);
    chk("done_state", seg1, seg_of(4'd4));
    chk("done_wr_en", wr_en, 0);
    leave_to_idle();

    // Second pass differs in word 2.
    enroll(PW_A, PW_BAD);
    drive(1'b1, 16'h0, 1'b1);
    chk("fail_hold", seg1, seg_of(4'd5));
    leave_to_idle();

    // Backpressure at idx 1.
    enroll(PW_A, PW_A);
    drive(1'b1, 16'h0, 1'b1);
    chk("bp_addr1", wr_addr, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0, 1'b0);
      chk("bp_wr_en", wr_en, 1);
      chk("bp_addr", wr_addr, 1);
      chk("bp_data", wr_data, 16'hEF93);
      chk("bp_led_idx", LED[7:0], 8'h02);
    end
    drive(1'b1, 16'h0, 1'b1);
    chk("bp_release_addr", wr_addr, 2);
    chk("bp_release_led", LED[7:0], 8'h04);
    wait_done(k);
    chk("bp_done", LED, 32'h8000);
    leave_to_idle();

    // Abort on the second edge of ENTER2, then re-enroll.
    drive(1'b1, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, PW_A[16*i +: 16], 1'b1);
    drive(1'b1, PW_A[15:0], 1'b1);
    drive(1'b0, PW_A[31:16], 1'b1);
    chk("abort_state", seg1, seg_of(4'd0));
    chk("abort_led", LED, 0);
    chk("abort_wr_en", wr_en, 0);
    enroll(PW_A, PW_A);
    wait_done(k);
    chk("reenroll_done", LED, 32'h8000);
    leave_to_idle();

    // Reset after two accepted writes in COMMIT.
    enroll(PW_A, PW_A);
    drive(1'b1, 16'h0, 1'b1);
    drive(1'b1, 16'h0, 1'b1);
    chk("pre_rst_addr", wr_addr, 2);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    reset = 1'b1;
    drive(1'b1, 16'h0, 1'b0);
    reset = 1'b0;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_led", LED, 0);
    chk("mid_rst_seg0", seg0, 7'h40);
    chk("mid_rst_seg1", seg1, 7'h40);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
